// File: rtl/vec_dmem_ram_if.sv
// ----------------------------------------------------------------------------
// vec_dmem_ram_if
//   Bus bundle for the vector data memory: the MEM-stage vector access port
//   (we/re/address/wd/lane_mask in, rd/rd_valid/oob_err out) and the dump
//   streamer port (dump_start/dump_ready in, dump_valid/dump_addr/dump_data/
//   dump_busy/dump_done out).
//   master : the pipeline / DMA side that drives requests
//   slave  : the memory itself
// ----------------------------------------------------------------------------
interface vec_dmem_ram_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 17
);
    // vector access port
    logic                    we;
    logic                    re;
    logic [ADDR_W-1:0]       address;
    logic [LANES*DATA_W-1:0] wd;
    logic [LANES-1:0]        lane_mask;
    logic [LANES*DATA_W-1:0] rd;
    logic                    rd_valid;
    logic                    oob_err;

    // dump streamer port
    logic                    dump_start;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [ADDR_W-1:0]       dump_addr;
    logic [DATA_W-1:0]       dump_data;
    logic                    dump_busy;
    logic                    dump_done;

    modport master (
        output we, re, address, wd, lane_mask, dump_start, dump_ready,
        input  rd, rd_valid, oob_err, dump_valid, dump_addr, dump_data,
               dump_busy, dump_done
    );

    modport slave (
        input  we, re, address, wd, lane_mask, dump_start, dump_ready,
        output rd, rd_valid, oob_err, dump_valid, dump_addr, dump_data,
               dump_busy, dump_done
    );
endinterface

// File: rtl/vec_dmem_ram.sv
// ----------------------------------------------------------------------------
// vec_dmem_ram
//   LANES-wide vector data memory with per-lane write masking, registered
//   reads (latency 1, read-first on collisions), bounds checking and a
//   valid/ready dump streamer that drains words 0..DEPTH-1 in order.
//
//   Ports:
//     clk  : clock, everything on the rising edge
//     rst  : synchronous active-high reset (storage is not cleared)
//     bus  : vec_dmem_ram_if.slave, access port + dump port
//
//   Storage is split into LANES banks interleaved on the low address bits, so
//   an unaligned vector access touches each bank exactly once per cycle.
//   Each bank is a simple dual-port RAM: port A serves vector access, port B
//   serves the dump streamer. LANES must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module vec_dmem_ram #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int DEPTH  = 129600,
    parameter int ADDR_W = 17
) (
    input  logic          clk,
    input  logic          rst,
    vec_dmem_ram_if.slave bus
);
    localparam int LANE_W     = $clog2(LANES);
    localparam int AW1        = ADDR_W + 1;
    localparam int BANK_DEPTH = (DEPTH + LANES - 1) / LANES;
    localparam int BROW_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam logic [AW1-1:0] DEPTH_A = AW1'(DEPTH);
    localparam logic [AW1-1:0] LAST_A  = AW1'(DEPTH - 1);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t state_q, state_d;
    logic   busy;
    assign busy = (state_q == DUMP);

    // accesses are only honoured outside a dump
    logic wr_go, rd_go;
    assign wr_go = bus.we && !busy;
    assign rd_go = bus.re && !busy;

    // ------------------------------------------------------------------
    // Lane addresses: one extra bit so address+i never wraps into range
    // ------------------------------------------------------------------
    logic [AW1-1:0]   lane_addr [LANES];
    logic [LANES-1:0] lane_oob;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_addr[gi] = {1'b0, bus.address} + AW1'(gi);
            assign lane_oob[gi]  = (lane_addr[gi] >= DEPTH_A);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Dump streamer control
    // ------------------------------------------------------------------
    logic [AW1-1:0]    dump_ptr_q, dump_ptr_d;   // next word to fetch
    logic              dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
    logic              dump_done_q, dump_done_d;
    logic              dump_fetch;
    logic              dump_hs;

    assign dump_hs = dump_valid_q && bus.dump_ready;

    // The bank read register on port B is the output register itself: it only
    // loads when the output slot is empty or being consumed, which holds data
    // stable under back-pressure and sustains one word per cycle otherwise.
    always_comb begin
        state_d      = state_q;
        dump_ptr_d   = dump_ptr_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_done_d  = 1'b0;
        dump_fetch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump_start) begin
                    state_d    = DUMP;
                    dump_ptr_d = '0;
                end
            end
            DUMP: begin
                if (dump_hs && (dump_addr_q == LAST_A[ADDR_W-1:0])) begin
                    state_d      = IDLE;
                    dump_valid_d = 1'b0;
                    dump_done_d  = 1'b1;
                end else if ((!dump_valid_q || dump_hs) && (dump_ptr_q < DEPTH_A)) begin
                    dump_fetch   = 1'b1;
                    dump_valid_d = 1'b1;
                    dump_addr_d  = dump_ptr_q[ADDR_W-1:0];
                    dump_ptr_d   = dump_ptr_q + AW1'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [BROW_W-1:0] dump_row;
    assign dump_row = dump_ptr_q[LANE_W +: BROW_W];

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bank_rdata [LANES];
    logic [DATA_W-1:0] bank_ddata [LANES];

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [BANK_DEPTH];
            logic [LANE_W-1:0] lsel;     // lane that lands in this bank
            logic [BROW_W-1:0] row;
            logic              bank_we;
            logic              bank_re;
            logic [DATA_W-1:0] rdata_q;
            logic [DATA_W-1:0] ddata_q;

            assign lsel    = LANE_W'(gi) - bus.address[LANE_W-1:0];
            assign row     = lane_addr[lsel][LANE_W +: BROW_W];
            assign bank_we = wr_go && bus.lane_mask[lsel] && !lane_oob[lsel];
            assign bank_re = rd_go && !lane_oob[lsel];

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    mem[row] <= bus.wd[lsel*DATA_W +: DATA_W];
                end
            end

            // separate process from the write so a same-cycle write is not
            // seen by the read (read-first)
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                    ddata_q <= '0;
                end else begin
                    if (bank_re) begin
                        rdata_q <= mem[row];
                    end
                    if (dump_fetch) begin
                        ddata_q <= mem[dump_row];
                    end
                end
            end

            assign bank_rdata[gi] = rdata_q;
            assign bank_ddata[gi] = ddata_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-side and control registers
    // ------------------------------------------------------------------
    logic              rd_valid_q;
    logic              oob_err_q;
    logic [LANE_W-1:0] rd_base_q;   // low address bits of the last read
    logic [LANES-1:0]  rd_oob_q;    // lanes of the last read that were OOB

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_valid_q   <= 1'b0;
            oob_err_q    <= 1'b0;
            rd_base_q    <= '0;
            rd_oob_q     <= '0;
            dump_ptr_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_valid_q   <= rd_go;
            // masked-off lanes never flag, reads flag on any OOB lane
            oob_err_q    <= (wr_go && |(bus.lane_mask & lane_oob)) ||
                            (rd_go && |lane_oob);
            if (rd_go) begin
                rd_base_q <= bus.address[LANE_W-1:0];
                rd_oob_q  <= lane_oob;
            end
            dump_ptr_q   <= dump_ptr_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_done_q  <= dump_done_d;
        end
    end

    // rotate bank outputs back into lane order; OOB lanes read as zero
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rd
            logic [LANE_W-1:0] bsel;
            assign bsel = rd_base_q + LANE_W'(gi);
            assign bus.rd[gi*DATA_W +: DATA_W] = rd_oob_q[gi] ? '0 : bank_rdata[bsel];
        end
    endgenerate

    assign bus.rd_valid   = rd_valid_q;
    assign bus.oob_err    = oob_err_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_addr  = dump_addr_q;
    assign bus.dump_data  = bank_ddata[dump_addr_q[LANE_W-1:0]];
    assign bus.dump_busy  = busy;
    assign bus.dump_done  = dump_done_q;

endmodule

// File: tb/tb_vec_dmem_ram.sv
// ----------------------------------------------------------------------------
// tb_vec_dmem_ram
//   Two instances: a full-size memory for access/bounds/read-first checks and
//   a DEPTH=16 memory for the dump streamer and reset-abort checks.
//   Inputs change 2 time units after the rising edge, outputs are sampled
//   1 time unit after it.
// ----------------------------------------------------------------------------
module tb_vec_dmem_ram;
    localparam int BIG_DEPTH = 129600;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vec_dmem_ram_if #(.DATA_W(32), .LANES(4), .ADDR_W(17)) b_if ();
    vec_dmem_ram_if #(.DATA_W(32), .LANES(4), .ADDR_W(5))  s_if ();

    vec_dmem_ram #(.DATA_W(32), .LANES(4), .DEPTH(BIG_DEPTH), .ADDR_W(17)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    vec_dmem_ram #(.DATA_W(32), .LANES(4), .DEPTH(16), .ADDR_W(5)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard for the full-size memory
    // ------------------------------------------------------------------
    typedef struct {
        bit           rdv;
        bit           oob;
        logic [127:0] rd;
    } exp_t;

    exp_t         big_q[$];
    logic [31:0]  model_mem [int];
    logic [127:0] last_rd = '0;

    task automatic big_cyc(input bit we, input bit re, input int addr,
                           input logic [127:0] wd, input logic [3:0] mask);
        exp_t e;
        int   a;
        @(posedge clk);
        #2;
        b_if.we        = we;
        b_if.re        = re;
        b_if.address   = addr[16:0];
        b_if.wd        = wd;
        b_if.lane_mask = mask;
        e.rdv = re;
        e.oob = 1'b0;
        e.rd  = last_rd;
        // read-first: look up old contents before applying the write
        for (int i = 0; i < 4; i++) begin
            a = addr + i;
            if (a >= BIG_DEPTH) begin
                if (re || (we && mask[i])) e.oob = 1'b1;
                if (re) e.rd[i*32 +: 32] = '0;
            end else if (re) begin
                e.rd[i*32 +: 32] = model_mem.exists(a) ? model_mem[a] : 32'h0;
            end
        end
        if (re) last_rd = e.rd;
        for (int i = 0; i < 4; i++) begin
            a = addr + i;
            if (we && mask[i] && a < BIG_DEPTH) model_mem[a] = wd[i*32 +: 32];
        end
        big_q.push_back(e);
    endtask

    exp_t be;
    always @(posedge clk) begin
        #1;
        if (big_q.size() > 0) begin
            be = big_q.pop_front();
            $display("mem access: rd_valid=%0b oob_err=%0b rd=%h", b_if.rd_valid, b_if.oob_err, b_if.rd);
            chk("rd_valid", b_if.rd_valid, be.rdv);
            chk("oob_err", b_if.oob_err, be.oob);
            chk("rd", b_if.rd, be.rd);
        end
    end

    // ------------------------------------------------------------------
    // Dump monitor for the small memory
    // ------------------------------------------------------------------
    int          dump_q[$];
    bit          dmon_en  = 1'b0;
    bit          prev_valid = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    bit          exp_done;
    int          ev;
    int          hs_cnt   = 0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (dmon_en) begin
            exp_done = 1'b0;
            if (prev_valid && s_if.dump_ready) begin
                if (dump_q.size() == 0) begin
                    chk("dump_extra_hs", 1, 0);
                end else begin
                    ev = dump_q.pop_front();
                    $display("dump hs: addr=%0d data=%0h", prev_addr, prev_data);
                    chk("dump_addr", prev_addr, ev);
                    chk("dump_data", prev_data, ev);
                    hs_cnt++;
                    exp_done = (dump_q.size() == 0);
                end
            end else if (prev_valid && dump_q.size() > 0) begin
                chk("stall_valid", s_if.dump_valid, 1);
                chk("stall_addr", s_if.dump_addr, dump_q[0]);
                chk("stall_data", s_if.dump_data, dump_q[0]);
            end
            chk("dump_done", s_if.dump_done, exp_done);
            if (exp_done) chk("valid_drop_at_done", s_if.dump_valid, 0);
            if (s_if.dump_done) done_cnt++;
            chk("rd_valid_busy", s_if.rd_valid, 0);
            chk("oob_err_busy", s_if.oob_err, 0);
        end
        prev_valid = s_if.dump_valid;
        prev_addr  = s_if.dump_addr;
        prev_data  = s_if.dump_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [4:0] rdy_pat;
    bit         found;

    initial begin
        rst = 1'b1;
        b_if.we = 0; b_if.re = 0; b_if.address = '0; b_if.wd = '0; b_if.lane_mask = '0;
        b_if.dump_start = 0; b_if.dump_ready = 0;
        s_if.we = 0; s_if.re = 0; s_if.address = '0; s_if.wd = '0; s_if.lane_mask = '0;
        s_if.dump_start = 0; s_if.dump_ready = 0;
        rdy_pat = 5'b01101;   // bit c = ready in dump cycle c: 1,0,1,1,0
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", b_if.rd, 0);
        chk("rst_rd_valid", b_if.rd_valid, 0);
        chk("rst_oob_err", b_if.oob_err, 0);
        chk("rst_dump_valid", b_if.dump_valid, 0);
        chk("rst_dump_busy", b_if.dump_busy, 0);
        chk("rst_dump_done", b_if.dump_done, 0);
        chk("rst_dump_addr", b_if.dump_addr, 0);
        chk("rst_dump_data", s_if.dump_data, 0);
        #1;
        rst = 1'b0;

        // full write then read back
        big_cyc(1, 0, 10, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 4'b1111);
        big_cyc(0, 1, 10, '0, 4'b0000);
        big_cyc(0, 0, 0, '0, 4'b0000);

        // partial mask over zeros
        big_cyc(1, 0, 20, '0, 4'b1111);
        big_cyc(1, 0, 20, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b0101);
        big_cyc(0, 1, 20, '0, 4'b0000);

        // top-of-memory bounds
        big_cyc(1, 0, 129598, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 4'b1111);
        big_cyc(0, 1, 129598, '0, 4'b0000);
        big_cyc(1, 0, 129598, {32'h0, 32'h0, 32'h5555_0002, 32'h5555_0001}, 4'b0011);
        big_cyc(0, 1, 129598, '0, 4'b0000);
        big_cyc(0, 1, 131070, '0, 4'b0000);

        // read-first collision
        big_cyc(1, 0, 5, {32'h14, 32'h13, 32'h12, 32'h11}, 4'b1111);
        big_cyc(1, 1, 5, {32'h0, 32'h0, 32'h0, 32'h22}, 4'b0001);
        big_cyc(0, 1, 5, '0, 4'b0000);
        big_cyc(0, 0, 0, '0, 4'b0000);

        // random traffic over a preloaded window 100..119
        for (int k = 100; k <= 116; k += 4)
            big_cyc(1, 0, k, {$urandom, $urandom, $urandom, $urandom}, 4'b1111);
        for (int n = 0; n < 24; n++)
            big_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 100 + $urandom_range(0, 16),
                    {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
        big_cyc(0, 0, 0, '0, 4'b0000);
        big_cyc(0, 0, 0, '0, 4'b0000);
        @(posedge clk);
        #2;
        chk("big_q_drained", big_q.size(), 0);

        // ---------------- dump on the small memory ----------------
        for (int k = 0; k < 12; k += 4) begin
            @(posedge clk);
            #2;
            s_if.we = 1; s_if.address = 5'(k); s_if.lane_mask = 4'hf;
            s_if.wd = {k + 3, k + 2, k + 1, k};
        end
        // last preload write shares the cycle with dump_start
        @(posedge clk);
        #2;
        s_if.address = 5'd12; s_if.wd = {32'd15, 32'd14, 32'd13, 32'd12};
        s_if.dump_start = 1;
        dump_q.delete();
        for (int k = 0; k < 16; k++) dump_q.push_back(k);
        hs_cnt = 0; done_cnt = 0;
        dmon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", s_if.dump_busy, 1);
        chk("valid_not_yet", s_if.dump_valid, 0);
        #1;
        // accesses during the dump, including OOB lanes, must be ignored
        s_if.dump_start = 0; s_if.we = 1; s_if.re = 1; s_if.address = 5'd14;
        s_if.wd = {4{32'hDEAD_BEEF}}; s_if.lane_mask = 4'hf; s_if.dump_ready = 0;
        for (int c = 0; c < 100 && done_cnt == 0; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) chk("first_valid", s_if.dump_valid, 1);
            #1;
            s_if.dump_ready = rdy_pat[c % 5];
            if (c == 99) chk("dump_timeout", 0, 1);
        end
        s_if.we = 0; s_if.re = 0; s_if.dump_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        dmon_en = 1'b0;
        chk("dump_hs_count", hs_cnt, 16);
        chk("dump_done_count", done_cnt, 1);
        chk("busy_after_done", s_if.dump_busy, 0);

        // ---------------- reset during the 7th dump word ----------------
        #1;
        s_if.dump_start = 1; s_if.dump_ready = 1;
        @(posedge clk);
        #2;
        s_if.dump_start = 0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk);
            #1;
            if (s_if.dump_valid && s_if.dump_addr == 5'd6) found = 1'b1;
            else #1;
        end
        if (!found) chk("rst_word7_seen", 0, 1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rd", s_if.rd, 0);
        chk("abort_rd_valid", s_if.rd_valid, 0);
        chk("abort_oob_err", s_if.oob_err, 0);
        chk("abort_dump_valid", s_if.dump_valid, 0);
        chk("abort_dump_addr", s_if.dump_addr, 0);
        chk("abort_dump_data", s_if.dump_data, 0);
        chk("abort_dump_busy", s_if.dump_busy, 0);
        chk("abort_dump_done", s_if.dump_done, 0);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_done_after_abort", s_if.dump_done, 0);
            chk("idle_after_abort", s_if.dump_busy, 0);
        end
        // storage survives reset
        for (int k = 0; k < 16; k += 4) begin
            #1;
            s_if.re = 1; s_if.address = 5'(k);
            @(posedge clk);
            #1;
            $display("readback: addr=%0d rd=%h", k, s_if.rd);
            chk("readback_valid", s_if.rd_valid, 1);
            chk("readback_rd", s_if.rd, {k + 3, k + 2, k + 1, k});
        end
        #1;
        s_if.re = 0;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_dmem_ram.md
Name: vec_dmem_ram

Overview:
Parametrised vector data memory for the pipelined vector processor. Replaces the scalar word RAM with LANES-wide accesses, per-lane write masking, registered reads and bounds checking. Adds a hardware dump streamer with a valid/ready handshake, so the image buffer can be drained word by word to the host/UART path instead of dumped through a simulation file write. Sits in the MEM stage; the dump port connects to the output DMA.

Parameters:
DATA_W, 32, bits per element/word
LANES, 4, elements per vector access
DEPTH, 129600, words of storage (one 360x360 image)
ADDR_W, 17, word address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
we  in  1  vector write enable
re  in  1  vector read enable
address  in  ADDR_W  base word address; lane i accesses address+i
wd  in  LANES*DATA_W  write data, lane i in bits [i*DATA_W +: DATA_W]
lane_mask  in  LANES  per-lane write enable, qualifies we
rd  out  LANES*DATA_W  registered read data, same lane packing as wd
rd_valid  out  1  rd holds data for the read issued the previous cycle
oob_err  out  1  one-cycle pulse: an enabled lane addressed a word >= DEPTH
dump_start  in  1  start a full-memory dump, sampled in IDLE only
dump_valid  out  1  dump_data/dump_addr valid
dump_ready  in  1  consumer accepts the word when dump_valid && dump_ready
dump_addr  out  ADDR_W  word index of dump_data
dump_data  out  DATA_W  memory word
dump_busy  out  1  high in DUMP state
dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: rd=0, rd_valid=0, oob_err=0, dump_valid=0, dump_addr=0, dump_data=0, dump_busy=0, dump_done=0, FSM to IDLE. Storage contents are not cleared. Reset mid-dump aborts the dump; dump_done is not pulsed.
- Lane address = address+i, computed at ADDR_W+1 bits; it does not wrap. Lane i is out-of-bounds (OOB) when its lane address is >= DEPTH.
- Write: at the clock edge with we=1 and not busy, lane i is stored only if lane_mask[i]=1 and the lane is in bounds. OOB masked-in lanes are dropped and raise oob_err on the next cycle. Masked-off lanes never raise an error.
- Read: re=1 and not busy gives rd and rd_valid=1 on the next cycle (latency 1). OOB lanes return 0 and raise oob_err. rd holds its value while re=0, and rd_valid drops.
- Simultaneous we and re to an overlapping word: read-first. rd returns the old contents.
- FSM IDLE -> DUMP on dump_start=1. DUMP streams words 0..DEPTH-1 in order. First dump_valid comes 2 cycles after dump_start is sampled.
- While dump_valid=1 and dump_ready=0, dump_addr and dump_data must stay stable.
- With dump_ready held high, the dump sustains 1 word/cycle with no bubbles.
- DUMP -> IDLE in the cycle after the handshake for word DEPTH-1. dump_done pulses in that cycle, and dump_valid drops in the same cycle.
- In DUMP, we and re are ignored: no write, rd_valid=0, oob_err=0. dump_start is ignored while busy.
- A dump_start in the same cycle as we/re: that access is performed and the dump still starts. The dump reflects that write.

Test Plan:
1. Write: address=10, lane_mask=4'b1111, wd={D,C,B,A}. Then read at address 10 -> next cycle rd={D,C,B,A}, rd_valid=1, oob_err=0.
2. Partial mask: address=20, lane_mask=4'b0101 over preloaded zeros -> read returns lanes 0 and 2 written, lanes 1 and 3 still 0.
3. Bounds: write and then read at address=129598, all lanes masked in -> lanes 0-1 written and read back; lanes 2-3 dropped and read as 0; oob_err pulses once for each access.
4. Read-first: same cycle we=1 and re=1 at address 5, old word 0x11, new word 0x22 -> rd lane0=0x11; next read gives 0x22.
5. Dump with DEPTH overridden to 16 and memory preloaded mem[k]=k. dump_start, with dump_ready toggling 1,0,1,1,0... -> 16 handshakes with dump_addr=dump_data=0..15 in order, values stable during stalls, dump_done pulses once, we/re ignored while busy.
6. Assert rst at the 7th dump word -> all outputs 0 next cycle, no dump_done, memory contents intact on readback.
